// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the xoodyak command/data feeder.
// Optional macro XOOD_FEED_BYTESWAP_EN (consumed by xood_word_packer): byte-reverse host words.
package xoodyak_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BLK_W          = 352;
    localparam int unsigned OPW            = 6;
    localparam int unsigned FUNC_W         = 4;
    localparam int unsigned LEN_W          = 6;
    localparam int unsigned CNT_W          = 4;
    localparam int unsigned NWORDS         = BLK_W / WORD_W;
    localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

    // Opmode bit positions: {continue, keyed, func[3:0]}
    localparam int unsigned OP_CONT  = 5;
    localparam int unsigned OP_KEYED = 4;

    typedef enum logic [FUNC_W-1:0] {
        FN_IDLE    = 4'd0,
        FN_KEY     = 4'd1,
        FN_NONCE   = 4'd2,
        FN_ASSOC   = 4'd3,
        FN_CRYPT   = 4'd4,
        FN_DECRYPT = 4'd5,
        FN_SQUEEZE = 4'd6,
        FN_RATCHET = 4'd7
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2
    } feed_state_e;

    localparam logic [LEN_W-1:0] MAXLEN_KEY         = 6'd16;
    localparam logic [LEN_W-1:0] MAXLEN_NONCE       = 6'd16;
    localparam logic [LEN_W-1:0] MAXLEN_ASSOC_KEYED = 6'd44;
    localparam logic [LEN_W-1:0] MAXLEN_ASSOC_PLAIN = 6'd16;
    localparam logic [LEN_W-1:0] MAXLEN_CRYPT       = 6'd24;
    localparam logic [LEN_W-1:0] MAXLEN_NONE        = 6'd0;

    // Largest byte count a function may carry in one block.
    function automatic logic [LEN_W-1:0] max_len(input logic [FUNC_W-1:0] func,
                                                 input logic              keyed);
        case (func)
            FN_KEY:     return MAXLEN_KEY;
            FN_NONCE:   return MAXLEN_NONCE;
            FN_ASSOC:   return keyed ? MAXLEN_ASSOC_KEYED : MAXLEN_ASSOC_PLAIN;
            FN_CRYPT:   return MAXLEN_CRYPT;
            FN_DECRYPT: return MAXLEN_CRYPT;
            default:    return MAXLEN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/xood_word_packer.sv
// Places one host word into its slot of the 352-bit block, zeroing bytes past len.
// Macro XOOD_FEED_BYTESWAP_EN: byte-reverse each host word before packing.
module xood_word_packer
    import xoodyak_pkg::*;
(
    input  logic [CNT_W-1:0]  idx,
    input  logic [WORD_W-1:0] data,
    input  logic [LEN_W-1:0]  len,
    output logic [BLK_W-1:0]  wr_en_c,
    output logic [BLK_W-1:0]  wr_data_c
);

    logic [WORD_W-1:0] ordered;
    logic [WORD_W-1:0] masked;
    logic [8:0]        sh;

    // Byte order, length masking and left-justified placement of word idx.
    always_comb begin
`ifdef XOOD_FEED_BYTESWAP_EN
        ordered = {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
        ordered = data;
`endif
        masked = '0;
        for (int j = 0; j < int'(BYTES_PER_WORD); j++) begin
            // Byte j of the word (j=0 is the first, most significant byte)
            if ((7'({idx, 2'b00}) + 7'(j)) < 7'(len)) begin
                masked[8*(3-j) +: 8] = ordered[8*(3-j) +: 8];
            end
        end
        sh        = 9'(BLK_W - WORD_W) - 9'(idx) * 9'(WORD_W);
        wr_data_c = BLK_W'(masked) << sh;
        wr_en_c   = BLK_W'({WORD_W{1'b1}}) << sh;
    end

endmodule

// File: rtl/xoodyak_feeder.sv
// Command/data staging for xoodyak_build: packs a 32-bit word stream into the
// 352-bit input_data block and holds it with opmode until the core finishes.
// Macro XOOD_FEED_BYTESWAP_EN (see xood_word_packer) selects little-endian hosts.
module xoodyak_feeder
    import xoodyak_pkg::*;
(
    input  logic              eph1,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FUNC_W-1:0] cmd_func,
    input  logic              cmd_keyed,
    input  logic              cmd_last,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    input  logic              core_finished,
    output logic [BLK_W-1:0]  input_data,
    output logic [OPW-1:0]    opmode,
    output logic              busy,
    output logic              cmd_err
);

    feed_state_e       state;
    logic [FUNC_W-1:0] func_r;
    logic              keyed_r;
    logic              last_r;
    logic [LEN_W-1:0]  len_r;
    logic [CNT_W-1:0]  cnt;
    logic [BLK_W-1:0]  buf_r;

    logic [CNT_W-1:0]  cmd_nwords_c;
    logic [CNT_W-1:0]  ld_nwords_c;
    logic              cmd_bad_c;
    logic              word_take_c;
    logic              last_word_c;
    logic [BLK_W-1:0]  wr_en_c;
    logic [BLK_W-1:0]  wr_data_c;
    logic [BLK_W-1:0]  buf_next_c;

    xood_word_packer u_packer (
        .idx       (cnt),
        .data      (word_data),
        .len       (len_r),
        .wr_en_c   (wr_en_c),
        .wr_data_c (wr_data_c)
    );

    // Command legality, word counts and the buffer image after a word write.
    always_comb begin
        cmd_nwords_c = CNT_W'((7'(cmd_len) + 7'd3) >> 2);
        ld_nwords_c  = CNT_W'((7'(len_r) + 7'd3) >> 2);
        cmd_bad_c    = (cmd_func > 4'(FN_RATCHET)) || (cmd_len > max_len(cmd_func, cmd_keyed));
        word_take_c  = word_valid & word_ready;
        last_word_c  = (cnt == (ld_nwords_c - CNT_W'(1)));
        buf_next_c   = (buf_r & ~wr_en_c) | (wr_data_c & wr_en_c);
    end

    // Feeder FSM with registered handshakes and core-facing outputs.
    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            func_r     <= '0;
            keyed_r    <= 1'b0;
            last_r     <= 1'b0;
            len_r      <= '0;
            cnt        <= '0;
            buf_r      <= '0;
            input_data <= '0;
            opmode     <= '0;
            cmd_ready  <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_bad_c) begin
                            cmd_err <= 1'b1;
                        end else begin
                            func_r    <= cmd_func;
                            keyed_r   <= cmd_keyed;
                            last_r    <= cmd_last;
                            len_r     <= cmd_len;
                            buf_r     <= '0;
                            cnt       <= '0;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (cmd_nwords_c == '0) begin
                                // No payload: input_data is left as-is so the core bus does not toggle
                                state  <= ST_ISSUE;
                                opmode <= {~cmd_last, cmd_keyed, cmd_func};
                            end else begin
                                state      <= ST_LOAD;
                                word_ready <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_take_c) begin
                        buf_r <= buf_next_c;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_word_c) begin
                            state      <= ST_ISSUE;
                            word_ready <= 1'b0;
                            input_data <= buf_next_c;
                            opmode     <= {~last_r, keyed_r, func_r};
                        end
                    end
                end
                ST_ISSUE: begin
                    if (core_finished) begin
                        state     <= ST_IDLE;
                        opmode    <= '0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xoodyak_feeder.sv
// Directed self-checking bench for xoodyak_feeder (default byte order).
module tb_xoodyak_feeder;

    localparam int BW = 352;

    logic          eph1;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_func;
    logic          cmd_keyed;
    logic          cmd_last;
    logic [5:0]    cmd_len;
    logic          word_valid;
    logic          word_ready;
    logic [31:0]   word_data;
    logic          core_finished;
    logic [BW-1:0] input_data;
    logic [5:0]    opmode;
    logic          busy;
    logic          cmd_err;

    int n_checks;
    int n_fail;

    logic [BW-1:0] exp_key;
    logic [BW-1:0] exp_assoc;
    logic [BW-1:0] exp_full;
    logic [BW-1:0] exp_fresh;
    logic [31:0]   w;

    xoodyak_feeder dut (
        .eph1          (eph1),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_func      (cmd_func),
        .cmd_keyed     (cmd_keyed),
        .cmd_last      (cmd_last),
        .cmd_len       (cmd_len),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_data     (word_data),
        .core_finished (core_finished),
        .input_data    (input_data),
        .opmode        (opmode),
        .busy          (busy),
        .cmd_err       (cmd_err)
    );

    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] f, input logic k, input logic l, input logic [5:0] n);
        cmd_func  = f;
        cmd_keyed = k;
        cmd_last  = l;
        cmd_len   = n;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        word_valid = 1'b1;
        word_data  = d;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic finish_core();
        core_finished = 1'b1;
        tick();
        core_finished = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_func      = '0;
        cmd_keyed     = 1'b0;
        cmd_last      = 1'b0;
        cmd_len       = '0;
        word_valid    = 1'b0;
        word_data     = '0;
        core_finished = 1'b0;

        exp_key   = {128'h38393a3b3c3d3e3f3031323334353637, 224'h0};
        exp_assoc = {48'h616263646566, 304'h0};
        exp_fresh = {128'h11111111222222223333333344444444, 224'h0};
        exp_full  = '0;

        // Reset values while reset is held across clock edges
        #12;
        check("rst_cmd_ready", BW'(cmd_ready), BW'(1'b0));
        check("rst_word_ready", BW'(word_ready), BW'(1'b0));
        check("rst_opmode", BW'(opmode), BW'(6'h00));
        check("rst_input_data", input_data, '0);
        check("rst_busy", BW'(busy), BW'(1'b0));
        check("rst_cmd_err", BW'(cmd_err), BW'(1'b0));
        reset_n = 1'b1;
        tick();
        check("idle_cmd_ready", BW'(cmd_ready), BW'(1'b1));

        // Key load: 16 bytes, keyed, last
        send_cmd(4'd1, 1'b1, 1'b1, 6'd16);
        check("key_word_ready", BW'(word_ready), BW'(1'b1));
        check("key_cmd_ready", BW'(cmd_ready), BW'(1'b0));
        check("key_busy", BW'(busy), BW'(1'b1));
        send_word(32'h38393a3b);
        send_word(32'h3c3d3e3f);
        send_word(32'h30313233);
        check("key_opmode_early", BW'(opmode), BW'(6'h00));
        send_word(32'h34353637);
        check("key_opmode", BW'(opmode), BW'(6'h11));
        check("key_data", input_data, exp_key);
        check("key_word_ready_issue", BW'(word_ready), BW'(1'b0));
        tick();
        tick();
        tick();
        check("key_opmode_hold", BW'(opmode), BW'(6'h11));
        check("key_data_hold", input_data, exp_key);
        finish_core();
        check("key_opmode_done", BW'(opmode), BW'(6'h00));
        check("key_data_kept", input_data, exp_key);
        check("key_busy_done", BW'(busy), BW'(1'b0));
        check("key_cmd_ready_done", BW'(cmd_ready), BW'(1'b1));

        // core_finished in IDLE has no effect
        finish_core();
        check("idle_fin_busy", BW'(busy), BW'(1'b0));
        check("idle_fin_opmode", BW'(opmode), BW'(6'h00));
        check("idle_fin_cmd_ready", BW'(cmd_ready), BW'(1'b1));

        // Partial assoc: 6 bytes, keyed, not last; trailing bytes of word 1 masked
        send_cmd(4'd3, 1'b1, 1'b0, 6'd6);
        send_word(32'h61626364);
        send_word(32'h65666768);
        check("assoc6_opmode", BW'(opmode), BW'(6'h33));
        check("assoc6_data", input_data, exp_assoc);
        finish_core();
        check("assoc6_opmode_done", BW'(opmode), BW'(6'h00));

        // Full assoc: 44 bytes with word_valid toggling
        send_cmd(4'd3, 1'b1, 1'b1, 6'd44);
        for (int i = 0; i < 11; i++) begin
            w = {8'(i + 1), 8'hc3, 8'h5a, 8'(i * 17)};
            exp_full[BW-1-32*i -: 32] = w;
            send_word(w);
            if (i < 10) begin
                word_data = 32'hffffffff;
                tick();
            end
            if (i == 9) begin
                check("full_opmode_pending", BW'(opmode), BW'(6'h00));
                check("full_busy_load", BW'(busy), BW'(1'b1));
            end
        end
        check("full_opmode", BW'(opmode), BW'(6'h13));
        check("full_data", input_data, exp_full);
        finish_core();

        // Squeeze with a simultaneous data word: only the command is taken
        word_valid = 1'b1;
        word_data  = 32'hdeadbeef;
        send_cmd(4'd6, 1'b1, 1'b1, 6'd0);
        word_valid = 1'b0;
        check("sq_opmode", BW'(opmode), BW'(6'h16));
        check("sq_word_ready", BW'(word_ready), BW'(1'b0));
        check("sq_data_kept", input_data, exp_full);
        finish_core();
        check("sq_opmode_done", BW'(opmode), BW'(6'h00));

        // Rejected commands
        send_cmd(4'd4, 1'b1, 1'b1, 6'd30);
        check("err_crypt_pulse", BW'(cmd_err), BW'(1'b1));
        check("err_crypt_busy", BW'(busy), BW'(1'b0));
        check("err_crypt_opmode", BW'(opmode), BW'(6'h00));
        tick();
        check("err_crypt_clear", BW'(cmd_err), BW'(1'b0));
        send_cmd(4'd9, 1'b0, 1'b1, 6'd0);
        check("err_func9_pulse", BW'(cmd_err), BW'(1'b1));
        check("err_func9_busy", BW'(busy), BW'(1'b0));
        send_cmd(4'd3, 1'b0, 1'b1, 6'd17);
        check("err_assoc17_pulse", BW'(cmd_err), BW'(1'b1));
        tick();
        check("err_clear", BW'(cmd_err), BW'(1'b0));
        check("err_opmode", BW'(opmode), BW'(6'h00));

        // Reset mid-LOAD, then a fresh key
        send_cmd(4'd1, 1'b1, 1'b1, 6'd16);
        send_word(32'haaaaaaaa);
        send_word(32'hbbbbbbbb);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", BW'(busy), BW'(1'b0));
        check("mid_rst_word_ready", BW'(word_ready), BW'(1'b0));
        check("mid_rst_cmd_ready", BW'(cmd_ready), BW'(1'b0));
        check("mid_rst_input_data", input_data, '0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        send_cmd(4'd1, 1'b1, 1'b1, 6'd16);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        check("fresh_opmode", BW'(opmode), BW'(6'h11));
        check("fresh_data", input_data, exp_fresh);
        finish_core();
        check("fresh_opmode_done", BW'(opmode), BW'(6'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xoodyak_feeder.md
Name: xoodyak_feeder

Overview:
- Upstream command/data staging stage for xoodyak_build.
- Accepts host commands (function, keyed flag, byte length, last flag) plus a 32-bit word stream, and packs the words into the 352-bit input_data block.
- Presents input_data and the 6-bit opmode to the core, holding both stable until the core pulses finished.
- Replaces the hand-indexed stimulus table, so software drives the core one word at a time.

Parameters:
- WORD_W, 32, host word width in bits. Fixed; BLK_W / WORD_W must be an integer.
- BLK_W, 352, core input_data width in bits (11 words, 44 bytes).
- OPW, 6, opmode width in bits.

Ports:
- eph1  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  feeder can accept a command.
- cmd_func  input  4  0 idle, 1 init/key, 2 nonce, 3 assoc, 4 crypt, 5 decrypt, 6 squeeze, 7 ratchet.
- cmd_keyed  input  1  keyed mode; becomes opmode[4].
- cmd_last  input  1  last block of this call; ~cmd_last becomes opmode[5] (continue).
- cmd_len  input  6  valid bytes in this block, 0..44.
- word_valid  input  1  data word present.
- word_ready  output  1  feeder accepts a word.
- word_data  input  32  data word; first byte is the most significant byte.
- core_finished  input  1  xoodyak_build finished pulse.
- input_data  output  352  packed block to the core.
- opmode  output  6  {continue, keyed, func}; 0 when not issuing.
- busy  output  1  state != IDLE.
- cmd_err  output  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async, reset_n=0): state IDLE, word counter 0, buffer 0, input_data 0, opmode 0, cmd_err 0, word_ready 0. cmd_ready is 0 while reset is asserted.
- Max bytes per function (MAXLEN):
  - key 16, nonce 16.
  - assoc 44 keyed / 16 unkeyed.
  - crypt 24, decrypt 24.
  - idle, squeeze, ratchet 0.
- nwords = ceil(cmd_len / 4), computed in 4 bits.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready with cmd_len>MAXLEN[func]: cmd_err=1 next cycle, command dropped, stay IDLE.
  - Otherwise: latch func, keyed, last and len; clear buffer and counter.
  - nwords==0 goes to ISSUE; else goes to LOAD.
- LOAD:
  - word_ready=1, cmd_ready=0.
  - Each word_valid&word_ready writes word k to bits [351-32k -: 32], then k increments.
  - When the accepted word is k==nwords-1, go to ISSUE next cycle.
  - Gaps in word_valid stall without loss.
- Packing:
  - Bytes at index >= len within the final word are forced to 0.
  - Unused trailing words remain 0.
  - Data is left-justified, e.g. a 16-byte key occupies [351:224].
- ISSUE:
  - input_data = buffer; opmode = {~last, keyed, func}.
  - Both held constant every cycle until core_finished=1 is sampled.
  - Next cycle: opmode=0, state IDLE. input_data keeps its last value (no toggle).
  - Latency from the last word accepted to opmode valid: 1 cycle. From command accept with len 0: 1 cycle.
- WAIT is merged into ISSUE; no separate state.
- Boundary conditions:
  - core_finished outside ISSUE is ignored.
  - core_finished in the same cycle ISSUE is entered is not possible: opmode is registered and the core needs at least 1 cycle.
  - Simultaneous cmd_valid and word_valid in IDLE: only the command is taken.
  - Words arriving in IDLE or ISSUE are not accepted (word_ready=0).
  - reset_n low mid-LOAD or mid-ISSUE: immediate return to reset values; partial block discarded.
  - cmd_func values 8..15 are rejected via cmd_err.

Optional Feature:
- Macro XOOD_FEED_BYTESWAP_EN.
- Defined: each word_data is byte-reversed before packing, for little-endian hosts. The first byte becomes bits [7:0] of the word, and len masking applies after the swap in byte order.
- Undefined: no swap; first byte is word_data[31:24].

Decomposition:
- Package xoodyak_pkg:
  - func_e enum (IDLE..RATCHET).
  - feed_state_e {IDLE, LOAD, ISSUE}.
  - MAXLEN constants; BLK_W and WORD_W.
  - Opmode bit positions OP_CONT=5, OP_KEYED=4.
- Sub-module xood_word_packer: word index, data and len in; masked, shifted 352-bit write-enable/data out. Combinational, instanced once.
- FSM and counters live in xoodyak_feeder.

Test Plan:
- Key load:
  - Stimulus: cmd func1 keyed=1 last=1 len16; words 38393a3b,3c3d3e3f,30313233,34353637.
  - Required: input_data = 128'h38393a3b3c3d3e3f3031323334353637 followed by 224'h0; opmode = 6'h11 held until core_finished, then 6'h00.
- Partial assoc:
  - Stimulus: func3 keyed len 6, no last; words 61626364,65666768.
  - Required: input_data[351:304] = 48'h616263646566, rest 0; opmode = 6'h33.
- Full assoc:
  - Stimulus: len 44, word_valid toggling every other cycle.
  - Required: all 11 words packed in order; ISSUE one cycle after the 11th accept.
- Squeeze:
  - Stimulus: func6 keyed last len0.
  - Required: no word_ready; opmode = 6'h16 one cycle after command accept; input_data holds its previous value.
- Error:
  - Stimulus: crypt len 30, then func 9 len 0.
  - Required: cmd_err pulses once for each; state stays IDLE; opmode stays 0.
- Reset during LOAD:
  - Stimulus: reset_n low after 2 of 4 key words.
  - Required: outputs zero asynchronously; the next command packs only fresh words.
